// File: rtl/seq_fixdiv_unit.sv
// rtl/seq_fixdiv_unit.sv - sequential restoring fixed-point divider with signed/unsigned mode
module seq_fixdiv_unit #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             valid,
  output logic             dvz,
  output logic             ovf,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  // Quotient magnitude limits, widened by one bit so the compares never wrap
  localparam logic [N:0] ONE_X = 1;
  localparam logic [N:0] U_MAX = (ONE_X << WIDTH) - ONE_X;
  localparam logic [N:0] S_POS = (ONE_X << (WIDTH - 1)) - ONE_X;
  localparam logic [N:0] S_NEG = ONE_X << (WIDTH - 1);

  localparam logic [WIDTH-1:0] SAT_SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_SMAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] magb_q, magb_d;
  logic [N-1:0]     d_q, d_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [N-1:0]     qm_q, qm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             qbit;
  logic             neg;
  logic             over;
  logic [N:0]       qm_ext;
  logic [WIDTH-1:0] qm_lo;

  // State and datapath registers; sclr discards any operation in flight
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      magb_q     <= '0;
      d_q        <= '0;
      rem_q      <= '0;
      qm_q       <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sgn_q      <= sgn_d;
      magb_q     <= magb_d;
      d_q        <= d_d;
      rem_q      <= rem_d;
      qm_q       <= qm_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      q_out_q    <= q_out_d;
      r_out_q    <= r_out_d;
    end
  end

  // Next-state, restoring-division step, result fix-up and status outputs
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sgn_d      = sgn_q;
    magb_d     = magb_q;
    d_d        = d_q;
    rem_d      = rem_q;
    qm_d       = qm_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    mag_a      = '0;
    rem_sh     = '0;
    rem_sub    = '0;
    qbit       = 1'b0;
    neg        = 1'b0;
    over       = 1'b0;
    qm_ext     = '0;
    qm_lo      = '0;
    busy       = (state_q != S_IDLE);
    valid      = (state_q == S_DONE) && !ovf_flag_q;
    ovf        = (state_q == S_DONE) && ovf_flag_q;
    dvz        = (state_q == S_ERR);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = a_in;
          b_d        = b_in;
          sgn_d      = is_signed;
          q_out_d    = '0;
          r_out_d    = '0;
          ovf_flag_d = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (b_q == '0) begin
          state_d = S_ERR;
        end else begin
          // Magnitudes are WIDTH-bit unsigned so the most negative value maps cleanly
          mag_a   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
          magb_d  = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
          d_d     = N'(mag_a) << FRAC;
          rem_d   = '0;
          qm_d    = '0;
          cnt_d   = CW'(N);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_sh = {rem_q, d_q[N-1]};
        if (rem_sh >= {1'b0, magb_q}) begin
          rem_sub = rem_sh - {1'b0, magb_q};
          rem_d   = rem_sub[WIDTH-1:0];
          qbit    = 1'b1;
        end else begin
          rem_d   = rem_sh[WIDTH-1:0];
        end
        d_d   = d_q << 1;
        qm_d  = {qm_q[N-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        neg    = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        qm_ext = {1'b0, qm_q};
        qm_lo  = qm_q[WIDTH-1:0];
        if (sgn_q) begin
          over = neg ? (qm_ext > S_NEG) : (qm_ext > S_POS);
        end else begin
          over = (qm_ext > U_MAX);
        end
        if (over) begin
          ovf_flag_d = 1'b1;
          r_out_d    = '0;
          if (SATURATE != 0) begin
            q_out_d = sgn_q ? (neg ? SAT_SMIN : SAT_SMAX) : '1;
          end else begin
            q_out_d = '0;
          end
        end else begin
          q_out_d = neg ? -qm_lo : qm_lo;
          r_out_d = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign q_out = q_out_q;
  assign r_out = r_out_q;

endmodule
